// File: rtl/result_writeback_controller_if.sv
// Handshake and memory-write bus for result_writeback_controller.
//   master : the controller (accepts pixels, drives memory writes, status)
//   slave  : the environment (pixel source, memory, frame control)
// Signals:
//   start             frame kick, sampled only while idle
//   in_valid/in_data  pixel stream, accepted on in_valid && in_ready
//   mem_we/addr/wdata write request, completes on mem_we && mem_ready
//   busy, row_done, complete  frame status
interface result_writeback_controller_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 18
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              row_done;
  logic              complete;

  modport master (
    input  start, in_valid, in_data, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, row_done, complete
  );

  modport slave (
    output start, in_valid, in_data, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, row_done, complete
  );
endinterface

// File: rtl/result_writeback_controller.sv
// Frame result writeback: buffers a processed pixel stream through a skid
// FIFO and writes it to external memory at consecutive addresses through a
// registered holding stage, flagging row and frame completion.
// Ports:
//   CLK  clock, rising edge
//   rst  synchronous active-high reset
//   bus  result_writeback_controller_if.master (stream in, memory out, status)
module result_writeback_controller #(
  parameter int DATA_W     = 8,
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int FIFO_DEPTH = 16
) (
  input logic CLK,
  input logic rst,
  result_writeback_controller_if.master bus
);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CNT_W  = $clog2(NPIX + 1);
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wptr, rptr;   // extra wrap bit separates full from empty
  logic [CNT_W-1:0]  in_cnt;
  logic [COL_W-1:0]  col;

  logic fifo_empty, fifo_full, push, pop, wr_done, last_acc;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                      (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  // Gated by rst so nothing is accepted in the reset cycle itself.
  assign bus.in_ready = !rst && (state == RUN) && !fifo_full;
  assign push     = bus.in_valid && bus.in_ready;
  assign wr_done  = bus.mem_we && bus.mem_ready;
  // Holding stage refills when empty or when its write retires this cycle.
  assign pop      = !fifo_empty && (!bus.mem_we || wr_done);
  assign last_acc = push && (in_cnt == CNT_W'(NPIX - 1));

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wptr[PTR_W-1:0]] <= bus.in_data;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state         <= IDLE;
      wptr          <= '0;
      rptr          <= '0;
      in_cnt        <= '0;
      col           <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
      bus.row_done  <= 1'b0;
      bus.complete  <= 1'b0;
    end else begin
      bus.row_done <= 1'b0;
      bus.complete <= 1'b0;

      if (push) begin
        wptr   <= wptr + 1'b1;
        in_cnt <= in_cnt + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;

      if (pop) begin
        bus.mem_we    <= 1'b1;
        bus.mem_wdata <= fifo_mem[rptr[PTR_W-1:0]];
      end else if (wr_done) begin
        bus.mem_we <= 1'b0;
      end

      // mem_addr tracks completed writes; it saturates on the last pixel so
      // it never points past the frame.
      if (wr_done) begin
        if (bus.mem_addr != ADDR_W'(NPIX - 1)) bus.mem_addr <= bus.mem_addr + 1'b1;
        if (col == COL_W'(IMG_W - 1)) begin
          col          <= '0;
          bus.row_done <= 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      case (state)
        IDLE: if (bus.start) begin
          state        <= RUN;
          bus.busy     <= 1'b1;
          wptr         <= '0;
          rptr         <= '0;
          in_cnt       <= '0;
          col          <= '0;
          bus.mem_addr <= '0;
        end
        RUN: if (last_acc) state <= DRAIN;
        // Everything was pushed before DRAIN, so an empty FIFO plus a
        // retiring (or idle) holding stage means the frame is written.
        DRAIN: if (fifo_empty && (!bus.mem_we || bus.mem_ready)) begin
          state        <= DONE;
          bus.complete <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/result_writeback_controller.md
RESULT_WRITEBACK_CONTROLLER -- requirements
Module: result_writeback_controller

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 512: pixels per row.
REQ-003 The block SHALL have parameter IMG_H, default 512: rows per frame.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16: skid FIFO entries, a power of two and at least 2.
REQ-005 The block SHALL have port CLK, input, 1: clock; all logic on the rising edge.
REQ-006 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 The block SHALL have port start, input, 1: begin frame writeback; sampled only in IDLE.
REQ-008 The block SHALL have port in_valid, input, 1: processed pixel present on in_data.
REQ-009 The block SHALL have port in_data, input, DATA_W: processed pixel.
REQ-010 The block SHALL have port in_ready, output, 1: the pixel is accepted in a cycle where in_valid && in_ready.
REQ-011 The block SHALL have port mem_we, output, 1: external memory write request.
REQ-012 The block SHALL have port mem_addr, output, clog2(IMG_W*IMG_H) (18 at defaults): write address.
REQ-013 The block SHALL have port mem_wdata, output, DATA_W: write data.
REQ-014 The block SHALL have port mem_ready, input, 1: the write completes in a cycle where mem_we && mem_ready.
REQ-015 The block SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 The block SHALL have port row_done, output, 1: one-cycle pulse after each completed row of writes.
REQ-017 The block SHALL have port complete, output, 1: one-cycle pulse when the frame is fully written.

Function
REQ-018 The state machine SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-019 Transition IDLE->RUN SHALL occur on start; the entry clears in_cnt, the write address, the column count and the FIFO.
REQ-020 Transition RUN->DRAIN SHALL occur in the cycle the IMG_W*IMG_H-th pixel is accepted.
REQ-021 Transition DRAIN->DONE SHALL occur when the FIFO is empty and the last write has completed.
REQ-022 Transition DONE->IDLE SHALL occur unconditionally after one cycle.
REQ-023 in_ready SHALL equal (state==RUN) && !fifo_full; in_ready is low in IDLE, DRAIN and DONE.
REQ-024 A push SHALL be refused when the FIFO is full, even if a pop occurs in the same cycle.
REQ-025 Simultaneous push and pop on a non-full FIFO SHALL leave the FIFO occupancy unchanged.
REQ-026 The output stage SHALL be a registered holding register driving mem_we, mem_addr and mem_wdata.
REQ-027 The holding register SHALL load from the FIFO when it is empty, or when its write completes in the same cycle, and the FIFO is non-empty.
REQ-028 While mem_we=1 && mem_ready=0, mem_addr and mem_wdata SHALL hold stable and mem_we SHALL stay high.
REQ-029 Latency: a pixel accepted in cycle N into an empty FIFO with an idle output stage SHALL appear with mem_we=1 in cycle N+2.
REQ-030 With mem_ready held high, the block SHALL sustain one write per cycle.
REQ-031 mem_addr SHALL start at 0 and increment by 1 per completed write, in the same order as acceptance.
REQ-032 mem_addr SHALL never exceed IMG_W*IMG_H-1; no write is issued beyond it.
REQ-033 The column counter SHALL count completed writes 0..IMG_W-1 and wrap to 0.
REQ-034 row_done SHALL pulse in the cycle after the column counter wraps.
REQ-035 complete SHALL be 1 only in DONE; the final row_done and complete may coincide.
REQ-036 start asserted in RUN, DRAIN or DONE SHALL be ignored.
REQ-037 in_valid asserted outside RUN SHALL have no effect.
REQ-038 All counters SHALL be unsigned, sized to their maximum value, and never overflow within a frame.

Reset
REQ-039 When rst=1, the block SHALL go to IDLE.
REQ-040 When rst=1, the outputs SHALL be in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, row_done=0 and complete=0.
REQ-041 When rst=1, the FIFO and all counters SHALL be flushed.
REQ-042 Reset SHALL take priority over all other inputs, including mid-frame and mid-stall; no further write is issued after reset.

Verification
REQ-043 Nominal (IMG_W=4, IMG_H=2, mem_ready=1, continuous in_valid, data 1..8) -> writes addr 0..7 with data 1..8 one per cycle, row_done twice, complete once, then IDLE.
REQ-044 Stall (mem_ready=0 for 20 cycles mid-frame) -> mem_addr/mem_wdata stable; in_ready drops after FIFO_DEPTH+1 accepts; no data lost or duplicated.
REQ-045 Latency (single pixel 0xA5 after idle) -> mem_we=1, mem_wdata=0xA5, mem_addr=0 exactly 2 cycles after acceptance.
REQ-046 Bursty input (random in_valid and mem_ready) -> write sequence equals input sequence in order; complete only after the 8th write completes.
REQ-047 Reset mid-frame (rst after 3 writes, then start) -> all outputs at reset values the next cycle; the new frame restarts at addr 0.
REQ-048 start pulses during RUN/DRAIN -> no counter clear and a single complete per frame.
